// File: rtl/bp_pkg.sv
// Shared types and default sizing for the branch-predictor update path.
// The scheduler, its FIFO and the predictor all pull their defaults from here.
package bp_pkg;

    localparam int BP_IDX_BITS  = 7;
    localparam int BP_UPD_DEPTH = 8;

    // One resolved branch outcome as buffered between retirement and the predictor.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_update_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        BLOCK
    } bp_upd_state_e;

    // Number of set bits in a two-slot valid vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Retirement and predictor-update bundle for bp_update_scheduler.
// With BP_UPD_PERF_EN defined the bundle also carries two saturating perf counters.
interface bp_update_scheduler_if #(
    parameter int DEPTH = 8
);
    // Retirement side
    logic [1:0]        ret_valid;
    logic [1:0][31:0]  ret_pc;
    logic [1:0]        ret_taken;
    logic [1:0][31:0]  ret_target;
    logic              ret_ready;

    // Predictor side
    logic              upd_stall;
    logic [1:0]        valid_update;
    logic [1:0][31:0]  PC_update;
    logic [1:0]        direction_update;
    logic [1:0][31:0]  target_update;

    // Status
    logic [$clog2(DEPTH):0] fifo_count;

`ifdef BP_UPD_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_backpressure_cnt;

    modport slave (
        input  ret_valid, ret_pc, ret_taken, ret_target, upd_stall,
        output ret_ready, valid_update, PC_update, direction_update, target_update,
        output fifo_count, perf_conflict_cnt, perf_backpressure_cnt
    );

    modport master (
        output ret_valid, ret_pc, ret_taken, ret_target, upd_stall,
        input  ret_ready, valid_update, PC_update, direction_update, target_update,
        input  fifo_count, perf_conflict_cnt, perf_backpressure_cnt
    );
`else
    modport slave (
        input  ret_valid, ret_pc, ret_taken, ret_target, upd_stall,
        output ret_ready, valid_update, PC_update, direction_update, target_update,
        output fifo_count
    );

    modport master (
        output ret_valid, ret_pc, ret_taken, ret_target, upd_stall,
        input  ret_ready, valid_update, PC_update, direction_update, target_update,
        input  fifo_count
    );
`endif

endinterface

// File: rtl/bp_update_fifo.sv
// Two-wide push / two-wide pop circular buffer of branch updates.
// Head and head+1 are read combinationally so the scheduler can decide the pair in one cycle.
// The storage array carries no reset; only the pointers and count are cleared.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             push_n_i,
    input  bp_update_t             wr0_i,
    input  bp_update_t             wr1_i,
    input  logic [1:0]             pop_n_i,
    output bp_update_t             head0_o,
    output bp_update_t             head1_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] count_next_o
);

    localparam int PW = $clog2(DEPTH);

    bp_update_t      mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic [PW-1:0]   head1_ptr;
    logic [PW-1:0]   tail1_ptr;

    assign head1_ptr = head_q + PW'(1);
    assign tail1_ptr = tail_q + PW'(1);

    // Write up to two already-packed entries at tail and tail+1
    always_ff @(posedge clock) begin
        if (push_n_i != 2'd0) begin
            mem_q[tail_q] <= wr0_i;
        end
        if (push_n_i == 2'd2) begin
            mem_q[tail1_ptr] <= wr1_i;
        end
    end

    // Pointer and occupancy arithmetic; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        head_d  = head_q + PW'(pop_n_i);
        tail_d  = tail_q + PW'(push_n_i);
        count_d = count_q + (PW+1)'(push_n_i) - (PW+1)'(pop_n_i);
    end

    // Pointer/count state, discarded on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head0_o      = mem_q[head_q];
    assign head1_o      = mem_q[head1_ptr];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/bp_update_scheduler.sv
// Sequences resolved branches from retirement into the predictor's two-wide update port.
// Pairs whose PC index collides on the BHT/selector tables are split across two cycles.
// Optional feature macro: BP_UPD_PERF_EN adds saturating conflict/backpressure counters.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH    = BP_UPD_DEPTH,
    parameter int IDX_BITS = BP_IDX_BITS
) (
    input logic                  clock,
    input logic                  reset_n,
    bp_update_scheduler_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    bp_upd_state_e   state_q;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            ready;
    logic [1:0]      accept;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    bp_update_t      slot0, slot1;
    bp_update_t      wr0, wr1;
    bp_update_t      head0, head1;
    logic            issue_en;
    logic            idx_differ;
    logic            have_two;
    logic [1:0]      valid_upd;

    // A full retire group must fit, judged on the registered count only
    assign ready = (count <= CW'(DEPTH - 2));

    assign accept = ready ? bus.ret_valid : 2'b00;
    assign push_n = popcount2(accept);

    assign slot0 = '{pc: bus.ret_pc[0], taken: bus.ret_taken[0], target: bus.ret_target[0]};
    assign slot1 = '{pc: bus.ret_pc[1], taken: bus.ret_taken[1], target: bus.ret_target[1]};

    // Pack valid slots in program order: a lone slot 1 lands in the first write position
    assign wr0 = accept[0] ? slot0 : slot1;
    assign wr1 = slot1;

    bp_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_n_i     (push_n),
        .wr0_i        (wr0),
        .wr1_i        (wr1),
        .pop_n_i      (pop_n),
        .head0_o      (head0),
        .head1_o      (head1),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // Issue decision: drain only in DRAIN and only if the predictor is not stalling right now
    assign issue_en   = (state_q == DRAIN) && !bus.upd_stall;
    assign have_two   = (count >= CW'(2));
    assign idx_differ = (head0.pc[IDX_BITS+1:2] != head1.pc[IDX_BITS+1:2]);

    always_comb begin
        valid_upd = 2'b00;
        if (issue_en) begin
            valid_upd = (have_two && idx_differ) ? 2'b11 : 2'b01;
        end
    end

    assign pop_n = popcount2(valid_upd);

    // Controller state follows the post-edge occupancy and the stall seen at that edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (count_next == '0) begin
            state_q <= IDLE;
        end else if (bus.upd_stall) begin
            state_q <= BLOCK;
        end else begin
            state_q <= DRAIN;
        end
    end

    assign bus.ret_ready           = ready;
    assign bus.valid_update        = valid_upd;
    assign bus.PC_update[0]        = head0.pc;
    assign bus.PC_update[1]        = head1.pc;
    assign bus.direction_update[0] = head0.taken;
    assign bus.direction_update[1] = head1.taken;
    assign bus.target_update[0]    = head0.target;
    assign bus.target_update[1]    = head1.target;
    assign bus.fifo_count          = count;

`ifdef BP_UPD_PERF_EN
    logic        split;
    logic        bp_event;
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_backpressure_q;

    assign split    = issue_en && have_two && !idx_differ;
    assign bp_event = (bus.ret_valid != 2'b00) && !ready;

    // Saturating count of cycles in which a same-index pair had to be split
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_conflict_q <= '0;
        end else if (split && (perf_conflict_q != '1)) begin
            perf_conflict_q <= perf_conflict_q + 32'd1;
        end
    end

    // Saturating count of cycles in which retirement was held off
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_backpressure_q <= '0;
        end else if (bp_event && (perf_backpressure_q != '1)) begin
            perf_backpressure_q <= perf_backpressure_q + 32'd1;
        end
    end

    assign bus.perf_conflict_cnt     = perf_conflict_q;
    assign bus.perf_backpressure_cnt = perf_backpressure_q;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench for bp_update_scheduler against a queue-based reference model.
module tb_bp_update_scheduler;

    localparam int DEPTH    = 8;
    localparam int IDX_BITS = 7;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    bp_update_scheduler_if #(.DEPTH(DEPTH)) bus ();

    bp_update_scheduler #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        q[$];
    bit          last_stall;
    int unsigned m_conf;
    int unsigned m_bp;
    int          checks = 0;
    int          errors = 0;

    logic [136:0] exp_v;
    logic [136:0] got_v;
    logic [1:0]   ev;

    // Entries the predictor should see this cycle
    function automatic int n_issue();
        if (q.size() == 0 || last_stall || bus.upd_stall) return 0;
        if (q.size() >= 2 && q[0].pc[IDX_BITS+1:2] != q[1].pc[IDX_BITS+1:2]) return 2;
        return 1;
    endfunction

    function automatic logic [1:0] exp_valid();
        int n = n_issue();
        return (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [136:0] exp_obs();
        int n = n_issue();
        logic [31:0] p0 = '0, t0 = '0, p1 = '0, t1 = '0;
        logic d0 = 1'b0, d1 = 1'b0;
        logic rdy = (q.size() <= DEPTH - 2);
        if (n >= 1) begin p0 = q[0].pc; d0 = q[0].taken; t0 = q[0].target; end
        if (n == 2) begin p1 = q[1].pc; d1 = q[1].taken; t1 = q[1].target; end
        return {rdy, 4'(q.size()), exp_valid(), p0, d0, t0, p1, d1, t1};
    endfunction

    function automatic logic [136:0] obs(input logic [1:0] m);
        return {bus.ret_ready, bus.fifo_count, bus.valid_update,
                bus.PC_update[0] & {32{m[0]}}, bus.direction_update[0] & m[0],
                bus.target_update[0] & {32{m[0]}},
                bus.PC_update[1] & {32{m[1]}}, bus.direction_update[1] & m[1],
                bus.target_update[1] & {32{m[1]}}};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic stall);
        bus.ret_valid     = v;
        bus.ret_pc[0]     = pc0;
        bus.ret_pc[1]     = pc1;
        bus.ret_taken[0]  = pc0[3] ^ pc0[9];
        bus.ret_taken[1]  = ~pc1[4];
        bus.ret_target[0] = pc0 ^ 32'h0000_5a40;
        bus.ret_target[1] = pc1 + 32'h0000_0200;
        bus.upd_stall     = stall;
    endtask

    // Advance one clock and apply the same cycle to the model
    task automatic tick();
        int   n   = n_issue();
        logic rdy = (q.size() <= DEPTH - 2);
        if (n == 1 && q.size() >= 2) m_conf++;
        if (bus.ret_valid != 2'b00 && !rdy) m_bp++;
        @(posedge clock);
        for (int i = 0; i < n; i++) void'(q.pop_front());
        if (rdy) begin
            for (int s = 0; s < 2; s++) begin
                if (bus.ret_valid[s])
                    q.push_back('{bus.ret_pc[s], bus.ret_taken[s], bus.ret_target[s]});
            end
        end
        last_stall = bus.upd_stall;
        @(negedge clock);
    endtask

    task automatic model_clear();
        q.delete();
        last_stall = 1'b0;
        m_conf = 0;
        m_bp = 0;
    endtask

    task automatic do_reset();
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b0;
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b0;
        model_clear();
        @(negedge clock);
        #1;
        checks++;
        if (bus.ret_ready !== 1'b1 || bus.valid_update !== 2'b00 || bus.fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b vu=%b cnt=%0d exp rdy=1 vu=00 cnt=0",
                     bus.ret_ready, bus.valid_update, bus.fifo_count);
        end
`ifdef BP_UPD_PERF_EN
        checks++;
        if (bus.perf_conflict_cnt !== 32'd0 || bus.perf_backpressure_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got conf=%0d bp=%0d exp 0 0",
                     bus.perf_conflict_cnt, bus.perf_backpressure_cnt);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_idle c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(2'b10, 32'h0, 32'h100, 1'b0);
            else        drive(2'b00, 32'h0, 32'h0, 1'b0);
            bus.ret_taken[1]  = 1'b1;
            bus.ret_target[1] = 32'h200;
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL single c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c == 1) begin
                checks++;
                if (bus.valid_update !== 2'b01 || bus.PC_update[0] !== 32'h100 ||
                    bus.direction_update[0] !== 1'b1 || bus.target_update[0] !== 32'h200) begin
                    errors++;
                    $display("FAIL single_fields got vu=%b pc=%h dir=%b tgt=%h exp vu=01 pc=100 dir=1 tgt=200",
                             bus.valid_update, bus.PC_update[0], bus.direction_update[0], bus.target_update[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_conflict();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(2'b11, 32'h100, 32'h300, 1'b0);
            else        drive(2'b00, 32'h0, 32'h0, 1'b0);
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL conflict c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (bus.valid_update !== 2'b01 || bus.PC_update[0] !== ((c == 1) ? 32'h100 : 32'h300)) begin
                    errors++;
                    $display("FAIL conflict_split c%0d got vu=%b pc=%h exp vu=01 pc=%h",
                             c, bus.valid_update, bus.PC_update[0], (c == 1) ? 32'h100 : 32'h300);
                end
            end
            tick();
        end
`ifdef BP_UPD_PERF_EN
        checks++;
        if (bus.perf_conflict_cnt !== 32'd1) begin
            errors++;
            $display("FAIL conflict_perf got=%0d exp=1", bus.perf_conflict_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] base = 32'h2000;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c < 3)       drive(2'b11, base + 32'(8 * c), base + 32'(8 * c + 4), 1'b1);
            else if (c == 3) drive(2'b01, base + 32'h18, 32'h0, 1'b1);
            else if (c < 7)  drive(2'b11, 32'hdead_0000, 32'hdead_0004, 1'b1);
            else             drive(2'b00, 32'h0, 32'h0, 1'b0);
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL backpressure c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c == 4) begin
                checks++;
                if (bus.fifo_count !== 4'd7 || bus.ret_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=7 rdy=0", bus.fifo_count, bus.ret_ready);
                end
            end
            tick();
        end
`ifdef BP_UPD_PERF_EN
        checks++;
        if (bus.perf_backpressure_cnt !== 32'(m_bp)) begin
            errors++;
            $display("FAIL bp_perf got=%0d exp=%0d", bus.perf_backpressure_cnt, m_bp);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            if (c < 20) drive(2'b11, 32'h1000 + 32'(16 * c), 32'h1000 + 32'(16 * c + 8), 1'b0);
            else        drive(2'b00, 32'h0, 32'h0, 1'b0);
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL wrap c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(2'($urandom_range(0, 3)),
                  32'h4000 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 1) << 9),
                  32'h4000 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 1) << 9),
                  ($urandom_range(0, 9) < 3));
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            tick();
        end
`ifdef BP_UPD_PERF_EN
        checks++;
        if (bus.perf_conflict_cnt !== 32'(m_conf) || bus.perf_backpressure_cnt !== 32'(m_bp)) begin
            errors++;
            $display("FAIL random_perf got conf=%0d bp=%0d exp conf=%0d bp=%0d",
                     bus.perf_conflict_cnt, bus.perf_backpressure_cnt, m_conf, m_bp);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 2)       drive(2'b11, 32'h3000 + 32'(8 * c), 32'h3000 + 32'(8 * c + 4), 1'b1);
            else if (c == 2) drive(2'b01, 32'h3010, 32'h0, 1'b1);
            else             drive(2'b00, 32'h0, 32'h0, 1'b0);
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (c < 4) tick();
        end
        // Now in the draining cycle with entries still buffered; pull reset between edges
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.ret_ready !== 1'b1 || bus.valid_update !== 2'b00 || bus.fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_async got rdy=%b vu=%b cnt=%0d exp rdy=1 vu=00 cnt=0",
                     bus.ret_ready, bus.valid_update, bus.fifo_count);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            ev = exp_valid(); exp_v = exp_obs(); got_v = obs(ev); checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_after c%0d got=%h exp=%h", c, got_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
